i2c_reg_slave: RTL and testbench
================================

// Module: i2c_reg_slave
// PURPOSE
//  Parametrised successor to the single-byte i2c_slave: an I2C target exposing NREGS x 8-bit
//  registers with an auto-incrementing pointer, sequential write/read bursts and repeated START.
//  Sits on the shared open-drain scl/sda nets beside i2c_master.
//  Local logic reads and writes the same register file through a parallel port.
// PARAMETERS
//  SLV_ADDR  7'h3b  7-bit target address matched on the bus
//  NREGS     16     register count, 2..256; PW = $clog2(NREGS) pointer bits
//  HOLD      2      clk cycles from detected scl fall to sda_out change (tHD:DAT)
// PORTS
//  clk       in   1   system clock; all logic on posedge
//  rst       in   1   synchronous reset, active-low
//  scl       in   1   bus clock (target never drives scl; no stretching)
//  sda       in   1   bus data, sampled
//  sda_out   out  1   0 = pull sda low, 1 = release (feeds bufif0 pin driver)
//  loc_addr  in   PW  local register address
//  loc_wdat  in   8   local write data
//  loc_we    in   1   local write strobe, one cycle
//  loc_rdat  out  8   reg[loc_addr], combinational read
//  wr_stb    out  1   one-cycle pulse per register written over I2C
//  wr_addr   out  PW  register index of the wr_stb write
//  busy      out  1   1 from START addressed to us until STOP / NACKed / mismatch
//  coll      out  1   sticky: local write lost to simultaneous I2C write; cleared by reset
// BEHAVIOUR
//  Reset (rst==0 at posedge): sda_out=1, all regs=0, ptr=0, wr_stb=0, busy=0, coll=0, state IDLE.
//  Input path: scl/sda through 2-flop synchroniser, then edge detect on synced values.
//  START = sda fall while scl high; STOP = sda rise while scl high; legal in any state.
//  Bits sampled on detected scl rise, MSB first; bit counter 0..8 (8 = ACK slot).
//  sda_out changes only HOLD cycles after a detected scl fall, never while scl high.
//  States:
//   IDLE  : wait START -> ADDR.
//   ADDR  : shift 8 bits; addr==SLV_ADDR -> AACK (busy=1), else -> IDLE until next START.
//   AACK  : drive 0 for 9th clock; R/W=0 -> PTR, R/W=1 -> RDATA (load reg[ptr]).
//   PTR   : shift byte; value < NREGS -> PACK, ptr=value; else release (NACK) -> IDLE.
//   PACK  : drive 0; -> WDATA.
//   WDATA : shift byte; at 8th scl rise write reg[ptr], wr_stb=1 for 1 cycle, wr_addr=ptr,
//           ptr = (ptr==NREGS-1) ? 0 : ptr+1; -> WACK (drive 0) -> WDATA.
//   RDATA : drive bit7..bit0 of shift reg; -> RACK, release sda; ptr increments (wraps)
//           when byte completes.
//   RACK  : sample master ACK; 0 -> RDATA with reg[ptr]; 1 (NACK) -> IDLE, busy=0.
//  Repeated START mid-transaction: -> ADDR; ptr retained (write-ptr-then-read sequence).
//  STOP anywhere: -> IDLE, sda_out=1 immediately, busy=0, ptr retained.
//  Read data snapshot taken at byte load; local writes during shift do not alter bits on bus.
//  Same-cycle loc_we and I2C write to same register: I2C value wins, coll<=1.
//  Same-cycle writes to different registers: both take effect.
//  Reset asserted mid-transfer: above reset values next edge; sda released within 1 cycle.
// CONFIGURATION
//  I2C_REG_SLAVE_FILT_EN defined: 3-sample majority filter on synced scl/sda before edge
//   detect; rejects 1-cycle glitches; adds 2 cycles input latency (HOLD counted after filter).
//  Undefined: no filter; a 1-cycle glitch on scl high is a valid edge.
// TESTING
//  1 Write 0x76,0x03,0xA1,0xB2,STOP -> ACK all; reg3=A1, reg4=B2; wr_stb x2, wr_addr 3,4.
//  2 Write 0x76,0x02, rSTART 0x77, read 3 bytes (ACK,ACK,NACK) -> reg2,reg3,reg4 on bus; ptr=5.
//  3 Write 0x76,0x0F,0x11,0x22 (NREGS=16) -> reg15=11, reg0=22 (wrap); ptr=1.
//  4 Address 0x3a, or pointer 0x20 -> sda never pulled low for that byte; busy=0; regs unchanged.
//  5 loc_we to reg4 (0x55) same cycle as I2C write reg4=0x99 -> reg4=99, coll=1.
//  6 rst low during 2nd data bit of a read -> sda_out=1 next cycle, regs 0; next START works.
//  7 FILT_EN build: 1-cycle scl pulse mid-byte -> ignored; without macro -> bit count corrupted.

Source files
------------

// File: rtl/i2c_reg_slave.sv
// I2C target with an NREGS x 8-bit register file, auto-incrementing pointer and a local parallel port.
// Optional build macro I2C_REG_SLAVE_FILT_EN adds a 3-sample majority glitch filter on scl/sda.
module i2c_reg_slave #(
  parameter logic [6:0] SLV_ADDR = 7'h3b,
  parameter int          NREGS    = 16,
  parameter int          HOLD     = 2,
  localparam int         PW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda,
  output logic          sda_out,
  input  logic [PW-1:0] loc_addr,
  input  logic [7:0]    loc_wdat,
  input  logic          loc_we,
  output logic [7:0]    loc_rdat,
  output logic          wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic          busy,
  output logic          coll
);

  typedef enum logic [3:0] {
    IDLE, ADDR, AACK, PTR, PACK, WDATA, WACK, RDATA, RACK
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    regs [NREGS];
  logic [7:0]    shift;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] ptr;
  logic          rw;
  logic [7:0]    hold_cnt;
  logic          scl_s1, scl_s2, sda_s1, sda_s2;
  logic          scl_f, sda_f, scl_q, sda_q;
  logic          drive, i2c_we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl;  scl_s2 <= scl_s1;
      sda_s1 <= sda;  sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_REG_SLAVE_FILT_EN
  logic [1:0] scl_h, sda_h;

  // Majority of the current and two previous synced samples; a lone 1-cycle pulse never wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_h <= 2'b11; sda_h <= 2'b11;
      scl_f <= 1'b1;  sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_s2};
      sda_h <= {sda_h[0], sda_s2};
      scl_f <= (scl_s2 & scl_h[0]) | (scl_s2 & scl_h[1]) | (scl_h[0] & scl_h[1]);
      sda_f <= (sda_s2 & sda_h[0]) | (sda_s2 & sda_h[1]) | (sda_h[0] & sda_h[1]);
    end
  end
`else
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  wire          scl_rise  = scl_f & ~scl_q;
  wire          scl_fall  = ~scl_f & scl_q;
  wire          start_det = scl_f & scl_q & sda_q & ~sda_f;
  wire          stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  wire          last_bit  = scl_rise && (bit_cnt == 4'd7);
  wire [7:0]    rx_byte   = {shift[6:0], sda_f};
  wire          addr_hit  = (rx_byte[7:1] == SLV_ADDR);
  wire          ptr_ok    = ({1'b0, rx_byte} < 9'(NREGS));
  wire [PW-1:0] ptr_inc   = (ptr == PW'(NREGS - 1)) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_det)       state_nxt = IDLE;
    else if (start_det) state_nxt = ADDR;
    else if (scl_rise) begin
      case (state)
        ADDR:    if (last_bit) state_nxt = addr_hit ? AACK : IDLE;
        AACK:    state_nxt = rw ? RDATA : PTR;
        PTR:     if (last_bit) state_nxt = ptr_ok ? PACK : IDLE;
        PACK:    state_nxt = WDATA;
        WDATA:   if (last_bit) state_nxt = WACK;
        WACK:    state_nxt = WDATA;
        RDATA:   if (last_bit) state_nxt = RACK;
        RACK:    state_nxt = sda_f ? IDLE : RDATA;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    drive  = 1'b1;
    i2c_we = (state == WDATA) && last_bit;
    case (state)
      AACK, PACK, WACK: drive = 1'b0;
      RDATA:            drive = shift[7];
      default:          drive = 1'b1;
    endcase
  end

  // The shift register doubles as receive buffer and as the read snapshot taken at byte load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift   <= '0;
      bit_cnt <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      busy    <= 1'b0;
    end else if (stop_det) begin
      busy <= 1'b0;
    end else if (start_det) begin
      bit_cnt <= '0;
    end else if (scl_rise) begin
      bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
      case (state)
        ADDR: begin
          shift <= rx_byte;
          if (last_bit) begin
            busy <= addr_hit;
            rw   <= sda_f;
          end
        end
        PTR: begin
          shift <= rx_byte;
          if (last_bit) begin
            if (ptr_ok) ptr  <= rx_byte[PW-1:0];
            else        busy <= 1'b0;
          end
        end
        WDATA: begin
          shift <= rx_byte;
          if (last_bit) ptr <= ptr_inc;
        end
        AACK: if (rw) shift <= regs[ptr];
        RDATA: begin
          shift <= {shift[6:0], 1'b0};
          if (last_bit) ptr <= ptr_inc;
        end
        RACK: begin
          if (sda_f) busy  <= 1'b0;
          else       shift <= regs[ptr];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      coll <= 1'b0;
    end else begin
      if (loc_we && !(i2c_we && (loc_addr == ptr))) regs[loc_addr] <= loc_wdat;
      if (i2c_we) regs[ptr] <= rx_byte;
      if (loc_we && i2c_we && (loc_addr == ptr)) coll <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_stb <= i2c_we;
      if (i2c_we) wr_addr <= ptr;
    end
  end

  // sda only moves once the hold window after a falling scl expires, and never while scl is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sda_out  <= 1'b1;
      hold_cnt <= '0;
    end else if (stop_det) begin
      sda_out  <= 1'b1;
      hold_cnt <= '0;
    end else begin
      if (scl_fall)             hold_cnt <= 8'(HOLD);
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - 8'd1;
      if ((hold_cnt == 8'd1) && !scl_f) sda_out <= drive;
    end
  end

  assign loc_rdat = regs[loc_addr];

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C master on a wired-AND sda, local port driver,
// write-strobe logger. Build with I2C_REG_SLAVE_FILT_EN defined to exercise the filtered variant.
module tb_i2c_reg_slave;

  localparam int Q = 10;
`ifdef I2C_REG_SLAVE_FILT_EN
  localparam int WE_DLY = 4;
`else
  localparam int WE_DLY = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_out, wr_stb, busy, coll;
  logic [3:0] loc_addr = '0;
  logic [7:0] loc_wdat = '0;
  logic       loc_we = 1'b0;
  logic [7:0] loc_rdat;
  logic [3:0] wr_addr;
  wire        sda_bus = sda_m & sda_out;

  int         checks = 0;
  int         errors = 0;
  int         low_cnt = 0;
  logic [3:0] wq[$];

  i2c_reg_slave dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus), .sda_out(sda_out),
    .loc_addr(loc_addr), .loc_wdat(loc_wdat), .loc_we(loc_we), .loc_rdat(loc_rdat),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .busy(busy), .coll(coll)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!sda_out) low_cnt++;
    if (wr_stb) wq.push_back(wr_addr);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One scl period; optionally pulses loc_we in the cycle the target commits this bit's byte.
  task automatic send_bit(input logic b, input bit coll_en, output logic got);
    sda_m = b;
    tick(Q);
    scl = 1'b1;
    if (coll_en) begin
      tick(WE_DLY);
      loc_we = 1'b1;
      tick(1);
      loc_we = 1'b0;
      tick(Q - WE_DLY - 1);
    end else begin
      tick(Q);
    end
    got = sda_bus;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit coll_en, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) send_bit(b[i], coll_en && (i == 0), g);
    send_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_bit);
    logic g;
    for (int i = 7; i >= 0; i--) send_bit(1'b1, 1'b0, d[i]);
    send_bit(ack_bit, 1'b0, g);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    loc_addr = a; loc_wdat = d; loc_we = 1'b1;
    tick(1);
    loc_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    checks++; if (sda_out !== 1'b1) begin errors++; $display("[TB] FAIL rst_sda_out: got %b want 1", sda_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    checks++; if (coll !== 1'b0) begin errors++; $display("[TB] FAIL rst_coll: got %b want 0", coll); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr_stb: got %b want 0", wr_stb); end
    loc_addr = 4'd5; #1;
    checks++; if (loc_rdat !== 8'h00) begin errors++; $display("[TB] FAIL rst_reg5: got %h want 00", loc_rdat); end
    rst = 1'b1;
    tick(4);
  endtask

  task automatic test_write_burst();
    logic a0, a1, a2, a3;
    wq.delete();
    i2c_start();
    write_byte(8'h76, 1'b0, a0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy: got %b want 1", busy); end
    write_byte(8'h03, 1'b0, a1);
    write_byte(8'hA1, 1'b0, a2);
    write_byte(8'hB2, 1'b0, a3);
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("[TB] FAIL wr_acks: got %b want 0000", {a0, a1, a2, a3}); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_busy_stop: got %b want 0", busy); end
    loc_addr = 4'd3; #1;
    checks++; if (loc_rdat !== 8'hA1) begin errors++; $display("[TB] FAIL wr_reg3: got %h want a1", loc_rdat); end
    loc_addr = 4'd4; #1;
    checks++; if (loc_rdat !== 8'hB2) begin errors++; $display("[TB] FAIL wr_reg4: got %h want b2", loc_rdat); end
    checks++; if (wq.size() !== 2) begin errors++; $display("[TB] FAIL wr_stb_count: got %0d want 2", wq.size()); end
    if (wq.size() == 2) begin
      checks++; if ({wq[0], wq[1]} !== 8'h34) begin errors++; $display("[TB] FAIL wr_addr_seq: got %h want 34", {wq[0], wq[1]}); end
    end
    tick(1);
  endtask

  task automatic test_read_burst();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    loc_write(4'd2, 8'h5C);
    loc_write(4'd5, 8'h6D);
    i2c_start();
    write_byte(8'h76, 1'b0, a0);
    write_byte(8'h02, 1'b0, a1);
    i2c_start();
    write_byte(8'h77, 1'b0, a2);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("[TB] FAIL rd_acks: got %b want 000", {a0, a1, a2}); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'h5C) begin errors++; $display("[TB] FAIL rd_byte0: got %h want 5c", d); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'hA1) begin errors++; $display("[TB] FAIL rd_byte1: got %h want a1", d); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'hB2) begin errors++; $display("[TB] FAIL rd_byte2: got %h want b2", d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rd_busy_nack: got %b want 0", busy); end
    i2c_stop();
    i2c_start();
    write_byte(8'h77, 1'b0, a3);
    read_byte(d, 1'b1);
    checks++; if (d !== 8'h6D) begin errors++; $display("[TB] FAIL rd_ptr5: got %h want 6d", d); end
    i2c_stop();
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3, a4;
    logic [7:0] d;
    loc_write(4'd1, 8'h3C);
    i2c_start();
    write_byte(8'h76, 1'b0, a0);
    write_byte(8'h0F, 1'b0, a1);
    write_byte(8'h11, 1'b0, a2);
    write_byte(8'h22, 1'b0, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("[TB] FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); end
    loc_addr = 4'd15; #1;
    checks++; if (loc_rdat !== 8'h11) begin errors++; $display("[TB] FAIL wrap_reg15: got %h want 11", loc_rdat); end
    loc_addr = 4'd0; #1;
    checks++; if (loc_rdat !== 8'h22) begin errors++; $display("[TB] FAIL wrap_reg0: got %h want 22", loc_rdat); end
    tick(1);
    i2c_start();
    write_byte(8'h77, 1'b0, a4);
    read_byte(d, 1'b1);
    i2c_stop();
    checks++; if (d !== 8'h3C) begin errors++; $display("[TB] FAIL wrap_ptr1: got %h want 3c", d); end
  endtask

  task automatic test_nack();
    logic a;
    wq.delete();
    low_cnt = 0;
    i2c_start();
    write_byte(8'h74, 1'b0, a);
    checks++; if (a !== 1'b1) begin errors++; $display("[TB] FAIL nack_addr: got %b want 1", a); end
    checks++; if (low_cnt !== 0) begin errors++; $display("[TB] FAIL nack_addr_low: got %0d want 0", low_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nack_addr_busy: got %b want 0", busy); end
    i2c_stop();
    i2c_start();
    write_byte(8'h76, 1'b0, a);
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL nack_addr_ok: got %b want 0", a); end
    low_cnt = 0;
    write_byte(8'h20, 1'b0, a);
    checks++; if (a !== 1'b1) begin errors++; $display("[TB] FAIL nack_ptr: got %b want 1", a); end
    checks++; if (low_cnt !== 0) begin errors++; $display("[TB] FAIL nack_ptr_low: got %0d want 0", low_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nack_ptr_busy: got %b want 0", busy); end
    write_byte(8'h55, 1'b0, a);
    checks++; if (a !== 1'b1) begin errors++; $display("[TB] FAIL nack_data: got %b want 1", a); end
    i2c_stop();
    loc_addr = 4'd0; #1;
    checks++; if (loc_rdat !== 8'h22) begin errors++; $display("[TB] FAIL nack_reg0: got %h want 22", loc_rdat); end
    checks++; if (wq.size() !== 0) begin errors++; $display("[TB] FAIL nack_wr_stb: got %0d want 0", wq.size()); end
    tick(1);
  endtask

  task automatic test_collision();
    logic a0, a1, a2, a3;
    i2c_start();
    write_byte(8'h76, 1'b0, a0);
    write_byte(8'h03, 1'b0, a1);
    loc_addr = 4'd4; loc_wdat = 8'h88;
    write_byte(8'h77, 1'b1, a2);
    checks++; if (coll !== 1'b0) begin errors++; $display("[TB] FAIL coll_diff_flag: got %b want 0", coll); end
    loc_addr = 4'd3; #1;
    checks++; if (loc_rdat !== 8'h77) begin errors++; $display("[TB] FAIL coll_diff_i2c: got %h want 77", loc_rdat); end
    loc_addr = 4'd4; #1;
    checks++; if (loc_rdat !== 8'h88) begin errors++; $display("[TB] FAIL coll_diff_loc: got %h want 88", loc_rdat); end
    tick(1);
    loc_addr = 4'd4; loc_wdat = 8'h55;
    write_byte(8'h99, 1'b1, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("[TB] FAIL coll_acks: got %b want 0000", {a0, a1, a2, a3}); end
    checks++; if (coll !== 1'b1) begin errors++; $display("[TB] FAIL coll_same_flag: got %b want 1", coll); end
    loc_addr = 4'd4; #1;
    checks++; if (loc_rdat !== 8'h99) begin errors++; $display("[TB] FAIL coll_same_reg4: got %h want 99", loc_rdat); end
    tick(1);
  endtask

  task automatic test_glitch();
    logic a, g;
    logic [7:0] d;
    logic [7:0] p;
    loc_write(4'd9, 8'h5A);
    p = 8'h09;
    i2c_start();
    write_byte(8'h76, 1'b0, a);
    for (int i = 7; i >= 4; i--) send_bit(p[i], 1'b0, g);
    scl = 1'b1;
    tick(1);
    scl = 1'b0;
    tick(Q);
    for (int i = 3; i >= 0; i--) send_bit(p[i], 1'b0, g);
    send_bit(1'b1, 1'b0, a);
    i2c_stop();
`ifdef I2C_REG_SLAVE_FILT_EN
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL glitch_ptr_ack: got %b want 0", a); end
`else
    checks++; if (a !== 1'b1) begin errors++; $display("[TB] FAIL glitch_ptr_ack: got %b want 1", a); end
`endif
    i2c_start();
    write_byte(8'h77, 1'b0, a);
    read_byte(d, 1'b1);
    i2c_stop();
`ifdef I2C_REG_SLAVE_FILT_EN
    checks++; if (d !== 8'h5A) begin errors++; $display("[TB] FAIL glitch_ptr_val: got %h want 5a", d); end
`else
    checks++; if (d !== 8'h99) begin errors++; $display("[TB] FAIL glitch_ptr_val: got %h want 99", d); end
`endif
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3, a4, a5, g;
    loc_write(4'd8, 8'h80);
    i2c_start();
    write_byte(8'h76, 1'b0, a0);
    write_byte(8'h08, 1'b0, a1);
    i2c_start();
    write_byte(8'h77, 1'b0, a2);
    send_bit(1'b1, 1'b0, g);
    checks++; if (g !== 1'b1) begin errors++; $display("[TB] FAIL mid_bit7: got %b want 1", g); end
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    checks++; if (sda_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_bit6_drive: got %b want 0", sda_out); end
    rst = 1'b0;
    tick(1);
    checks++; if (sda_out !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_release: got %b want 1", sda_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); end
    loc_addr = 4'd8; #1;
    checks++; if (loc_rdat !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_reg8: got %h want 00", loc_rdat); end
    tick(2);
    rst = 1'b1;
    tick(Q);
    i2c_start();
    write_byte(8'h76, 1'b0, a3);
    write_byte(8'h00, 1'b0, a4);
    write_byte(8'hC3, 1'b0, a5);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3, a4, a5} !== 6'b0) begin errors++; $display("[TB] FAIL mid_acks: got %b want 000000", {a0, a1, a2, a3, a4, a5}); end
    loc_addr = 4'd0; #1;
    checks++; if (loc_rdat !== 8'hC3) begin errors++; $display("[TB] FAIL mid_after_reg0: got %h want c3", loc_rdat); end
    tick(1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_nack();
    test_collision();
    test_glitch();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
